// File: rtl/fetch_stall_ctrl.sv
// Fetch-side hazard consumer: PC and IF/ID registers with stall hold and branch flush.
// Define PERF_CNT_EN to add the stall_cycles / flush_count saturating counters.
module fetch_stall_ctrl #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             br_taken,
   input  logic [WIDTH-1:0] br_target,
   input  logic [WIDTH-1:0] imem_instr,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] IFID_instr,
   output logic [WIDTH-1:0] IFID_pc4,
   output logic             IFID_valid,
   output logic             IDEX_bubble,
   output logic [1:0]       fe_state
`ifdef PERF_CNT_EN
   ,
   output logic [31:0]      stall_cycles,
   output logic [31:0]      flush_count
`endif
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HOLD  = 2'd1,
      ST_FLUSH = 2'd2
   } fe_state_t;

   fe_state_t        state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] ifid_instr_q, ifid_instr_d;
   logic [WIDTH-1:0] ifid_pc4_q, ifid_pc4_d;
   logic             ifid_valid_q, ifid_valid_d;
   logic [WIDTH-1:0] pc_plus4;
   logic             eff_br;

   assign pc_plus4 = pc_q + WIDTH'(4);
   // A branch still waiting on operands is stalled, and a squashed slot never redirects.
   assign eff_br   = br_taken & ifid_valid_q & ~stall;

   always_comb begin
      state_d      = ST_RUN;
      pc_d         = pc_plus4;
      ifid_instr_d = imem_instr;
      ifid_pc4_d   = pc_plus4;
      ifid_valid_d = 1'b1;
      if (stall) begin
         state_d      = ST_HOLD;
         pc_d         = pc_q;
         ifid_instr_d = ifid_instr_q;
         ifid_pc4_d   = ifid_pc4_q;
         ifid_valid_d = ifid_valid_q;
      end else if (eff_br) begin
         state_d      = ST_FLUSH;
         pc_d         = {br_target[WIDTH-1:2], 2'b00};
         ifid_instr_d = '0;
         ifid_pc4_d   = '0;
         ifid_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_RUN;
         pc_q         <= RESET_PC;
         ifid_instr_q <= '0;
         ifid_pc4_q   <= '0;
         ifid_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

   assign pc          = pc_q;
   assign IFID_instr  = ifid_instr_q;
   assign IFID_pc4    = ifid_pc4_q;
   assign IFID_valid  = ifid_valid_q;
   assign IDEX_bubble = stall & ~rst;
   assign fe_state    = state_q;

`ifdef PERF_CNT_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] flush_count_q, flush_count_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if (stall && (stall_cycles_q != 32'hFFFF_FFFF))
         stall_cycles_d = stall_cycles_q + 32'd1;
      if (eff_br && (flush_count_q != 32'hFFFF_FFFF))
         flush_count_d = flush_count_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`endif

endmodule
